// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite write-capture front end.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_W  = 3'd1,
    WAIT_AW = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_wr_capture.sv
// AXI4-Lite write-channel front end: captures AW/W in either order, pulses reg_wr_en, runs B.
// Optional address window check enabled by defining AXI_WR_ADDR_RANGE_CHECK_EN.
module axi_lite_wr_capture
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REG_SPACE_BYTES = 4096,
  localparam int unsigned STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic                  awaddr_done_reg,
  output logic                  wdata_done_reg,
  output logic [ADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_WIDTH-1:0] reg_wstrb,
  output logic                  reg_wr_en
);

  if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_data_width
    $error("axi_lite_wr_capture: DATA_WIDTH must be 32 or 64");
  end
  if (REG_SPACE_BYTES == 0) begin : g_bad_reg_space
    $error("axi_lite_wr_capture: REG_SPACE_BYTES must be non-zero");
  end

  wr_state_e  state;
  wr_state_e  state_next;
  logic       aw_hs_c;
  logic       w_hs_c;
  logic       wr_ok_c;
  logic [1:0] resp_c;

  assign aw_hs_c = s_axi_awvalid & s_axi_awready;
  assign w_hs_c  = s_axi_wvalid & s_axi_wready;

  // Range decision uses the address that will be held during WRITE.
`ifdef AXI_WR_ADDR_RANGE_CHECK_EN
  logic [ADDR_WIDTH-1:0] waddr_next_c;
  assign waddr_next_c = aw_hs_c ? s_axi_awaddr : reg_waddr;
  assign wr_ok_c      = 64'(waddr_next_c) < 64'(REG_SPACE_BYTES);
  assign resp_c       = (64'(reg_waddr) < 64'(REG_SPACE_BYTES)) ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_ok_c = 1'b1;
  assign resp_c  = RESP_OKAY;
`endif

  // Next-state decode; readies are registered so handshakes only occur in accepting states.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (aw_hs_c && w_hs_c) state_next = WRITE;
        else if (aw_hs_c)      state_next = WAIT_W;
        else if (w_hs_c)       state_next = WAIT_AW;
      end
      WAIT_W:  if (w_hs_c)  state_next = WRITE;
      WAIT_AW: if (aw_hs_c) state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    if (s_axi_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state           <= IDLE;
      s_axi_awready   <= 1'b0;
      s_axi_wready    <= 1'b0;
      s_axi_bvalid    <= 1'b0;
      s_axi_bresp     <= RESP_OKAY;
      awaddr_done_reg <= 1'b0;
      wdata_done_reg  <= 1'b0;
      reg_waddr       <= '0;
      reg_wdata       <= '0;
      reg_wstrb       <= '0;
      reg_wr_en       <= 1'b0;
    end else begin
      state           <= state_next;
      s_axi_awready   <= (state_next == IDLE) || (state_next == WAIT_AW);
      s_axi_wready    <= (state_next == IDLE) || (state_next == WAIT_W);
      s_axi_bvalid    <= (state_next == RESP);
      awaddr_done_reg <= (aw_hs_c | awaddr_done_reg) & (state_next != RESP);
      wdata_done_reg  <= (w_hs_c | wdata_done_reg) & (state_next != RESP);
      reg_wr_en       <= (state_next == WRITE) & wr_ok_c;
      if (aw_hs_c) reg_waddr <= s_axi_awaddr;
      if (w_hs_c) begin
        reg_wdata <= s_axi_wdata;
        reg_wstrb <= s_axi_wstrb;
      end
      // Response code is fixed on entry to RESP and held until bready.
      if (state == WRITE)           s_axi_bresp <= resp_c;
      else if (state_next != RESP)  s_axi_bresp <= RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_capture.sv
// Directed self-checking bench for axi_lite_wr_capture (default 32-bit configuration).
module tb_axi_lite_wr_capture;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic          aw_done;
  logic          w_done;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;
  logic          r_wr_en;

  int passed = 0;
  int total  = 0;

  axi_lite_wr_capture dut (
    .s_axi_aclk      (clk),
    .s_axi_areset    (rst),
    .s_axi_awaddr    (awaddr),
    .s_axi_awvalid   (awvalid),
    .s_axi_awready   (awready),
    .s_axi_wdata     (wdata),
    .s_axi_wstrb     (wstrb),
    .s_axi_wvalid    (wvalid),
    .s_axi_wready    (wready),
    .s_axi_bresp     (bresp),
    .s_axi_bvalid    (bvalid),
    .s_axi_bready    (bready),
    .awaddr_done_reg (aw_done),
    .wdata_done_reg  (w_done),
    .reg_waddr       (r_waddr),
    .reg_wdata       (r_wdata),
    .reg_wstrb       (r_wstrb),
    .reg_wr_en       (r_wr_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; awaddr = 32'h55; awvalid = 1'b1; wdata = 32'h1111_2222;
    wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;

    // Reset held two cycles with valids high
    tick();
    tick();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    check("rst_flags",   64'({aw_done, w_done}), 64'd0);
    check("rst_buses",   64'({r_waddr, r_wdata}), 64'd0);
    check("rst_wstrb",   64'(r_wstrb), 64'd0);
    check("rst_wr_en",   64'(r_wr_en), 64'd0);
    rst = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("post_rst_readies", 64'({awready, wready}), 64'b11);

    // Simultaneous AW/W handshake
    awaddr = 32'h10; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("sim_flags",   64'({aw_done, w_done}), 64'b11);
    check("sim_wr_en",   64'(r_wr_en), 64'd1);
    check("sim_waddr",   64'(r_waddr), 64'h10);
    check("sim_wdata",   64'(r_wdata), 64'hDEAD_BEEF);
    check("sim_wstrb",   64'(r_wstrb), 64'hF);
    check("sim_bvalid_n1", 64'(bvalid), 64'd0);
    check("sim_readies_write", 64'({awready, wready}), 64'b00);
    tick();
    check("sim_bvalid_n2", 64'(bvalid), 64'd1);
    check("sim_bresp",     64'(bresp),  64'd0);
    check("sim_wr_en_once", 64'(r_wr_en), 64'd0);
    check("sim_flags_clr", 64'({aw_done, w_done}), 64'b00);
    check("sim_bus_hold",  64'(r_wdata), 64'hDEAD_BEEF);
    bready = 1'b1;
    tick();
    check("sim_bvalid_drop", 64'(bvalid), 64'd0);
    check("sim_idle_readies", 64'({awready, wready}), 64'b11);
    // bready high while idle must not disturb anything
    tick();
    check("idle_bready_ignored", 64'({bvalid, awready, wready, r_wr_en}), 64'b0110);
    bready = 1'b0;

    // AW first, W three cycles later
    awaddr = 32'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("awf_n1_flags",  64'({aw_done, w_done}), 64'b10);
    check("awf_n1_readies", 64'({awready, wready}), 64'b01);
    check("awf_n1_wr_en", 64'(r_wr_en), 64'd0);
    tick();
    tick();
    check("awf_n3_flags",  64'({aw_done, w_done}), 64'b10);
    check("awf_n3_readies", 64'({awready, wready}), 64'b01);
    wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("awf_n4_wr_en", 64'(r_wr_en), 64'd1);
    check("awf_n4_flags", 64'({aw_done, w_done}), 64'b11);
    check("awf_n4_waddr", 64'(r_waddr), 64'h20);
    check("awf_n4_wdata", 64'(r_wdata), 64'h1234_5678);
    check("awf_n4_wstrb", 64'(r_wstrb), 64'h3);

    // Backpressure on B for five cycles, with a stray AW offered meanwhile
    tick();
    awaddr = 32'h99; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid",  64'(bvalid), 64'd1);
      check("bp_bresp",   64'(bresp),  64'd0);
      check("bp_readies", 64'({awready, wready}), 64'b00);
      check("bp_wr_en",   64'(r_wr_en), 64'd0);
      tick();
    end
    check("bp_waddr_hold", 64'(r_waddr), 64'h20);
    bready = 1'b1;
    tick();
    awvalid = 1'b0; bready = 1'b0;
    check("bp_release_bvalid", 64'(bvalid), 64'd0);
    check("bp_release_readies", 64'({awready, wready}), 64'b11);

    // Reset while waiting for W
    awaddr = 32'h30; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mid_wait_w", 64'({aw_done, w_done}), 64'b10);
    rst = 1'b1; wdata = 32'hAAAA_5555; wvalid = 1'b1;
    tick();
    check("mid_rst_wr_en",  64'(r_wr_en), 64'd0);
    check("mid_rst_flags",  64'({aw_done, w_done}), 64'b00);
    check("mid_rst_waddr",  64'(r_waddr), 64'h0);
    check("mid_rst_bvalid", 64'(bvalid), 64'd0);
    rst = 1'b0; wvalid = 1'b0;
    tick();
    check("mid_no_late_wr", 64'({r_wr_en, awready, wready}), 64'b011);
    awaddr = 32'h40; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hC; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    check("fresh_wr_en", 64'(r_wr_en), 64'd1);
    check("fresh_bus",   64'({r_waddr, r_wdata}), {32'h40, 32'hCAFE_F00D});
    check("fresh_wstrb", 64'(r_wstrb), 64'hC);
    tick();
    check("fresh_b", 64'({bvalid, bresp}), 64'b100);
    tick();
    check("fresh_done", 64'({bvalid, awready, wready}), 64'b011);

    // Address at and just below the register window boundary
    awaddr = 32'h1000; awvalid = 1'b1; wdata = 32'h0000_0001; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
`ifdef AXI_WR_ADDR_RANGE_CHECK_EN
    check("oor_wr_en", 64'(r_wr_en), 64'd0);
`else
    check("oor_wr_en", 64'(r_wr_en), 64'd1);
`endif
    check("oor_waddr", 64'(r_waddr), 64'h1000);
    tick();
    check("oor_bvalid", 64'(bvalid), 64'd1);
`ifdef AXI_WR_ADDR_RANGE_CHECK_EN
    check("oor_bresp", 64'(bresp), 64'b10);
`else
    check("oor_bresp", 64'(bresp), 64'b00);
`endif
    tick();
    awaddr = 32'hFFC; awvalid = 1'b1; wdata = 32'h0000_0002; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("inr_wr_en", 64'(r_wr_en), 64'd1);
    check("inr_waddr", 64'(r_waddr), 64'hFFC);
    tick();
    check("inr_b", 64'({bvalid, bresp}), 64'b100);
    tick();
    check("inr_done", 64'(bvalid), 64'd0);
    bready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_lite_wr_capture.md
Name: axi_lite_wr_capture

Overview:
- AXI4-Lite slave write-channel front end.
- Accepts write-address (AW) and write-data (W) handshakes independently and in either order, then captures address, data and strobe.
- Produces the level flags awaddr_done_reg / wdata_done_reg consumed by the downstream register-file stage, which delays them for edge detection.
- Issues a one-cycle register write strobe, then runs the B-channel response handshake.

Parameters:
- ADDR_WIDTH, 32, AW address width.
- DATA_WIDTH, 32, W data width; must be 32 or 64.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width; derived, not overridable.
- REG_SPACE_BYTES, 4096, decoded register window size; used only with the optional feature.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_areset  in  1  reset; synchronous, active-high.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1  AW valid.
- s_axi_awready  out  1  AW ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  STRB_WIDTH  byte strobes.
- s_axi_wvalid  in  1  W valid.
- s_axi_wready  out  1  W ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  B valid.
- s_axi_bready  in  1  B ready.
- awaddr_done_reg  out  1  address captured, level.
- wdata_done_reg  out  1  data captured, level.
- reg_waddr  out  ADDR_WIDTH  captured address.
- reg_wdata  out  DATA_WIDTH  captured data.
- reg_wstrb  out  STRB_WIDTH  captured strobes.
- reg_wr_en  out  1  one-cycle write strobe.

Behaviour:
- Reset value of every output is 0: readies, bvalid, bresp, flags, reg_* buses, reg_wr_en.
- Reset takes effect on the next s_axi_aclk edge.
- Reset mid-transaction: FSM returns to IDLE, the pending write is discarded (no reg_wr_en), bvalid drops.
- FSM states:
  - IDLE, WAIT_W (address held), WAIT_AW (data held), WRITE, RESP.
- Readies are driven from registered state only; no combinational path from valid to ready.
  - awready = 1 in IDLE and WAIT_AW.
  - wready = 1 in IDLE and WAIT_W.
  - Both readies are 0 in WRITE and RESP.
- AW handshake (awvalid & awready) at edge N:
  - Latch awaddr into reg_waddr.
  - awaddr_done_reg = 1 from cycle N+1.
- W handshake at edge N:
  - Latch wdata and wstrb.
  - wdata_done_reg = 1 from cycle N+1.
- Transitions:
  - IDLE with both handshakes in the same cycle -> WRITE.
  - IDLE with AW only -> WAIT_W.
  - IDLE with W only -> WAIT_AW.
  - WAIT_W with W handshake -> WRITE; WAIT_AW with AW handshake -> WRITE.
  - WRITE -> RESP unconditionally after 1 cycle.
  - RESP with bready -> IDLE.
- In WRITE: reg_wr_en = 1 for exactly one cycle; reg_* buses are stable in that cycle.
- Entering RESP:
  - bvalid = 1, bresp = 2'b00 (OKAY).
  - Both done flags clear.
  - reg_* buses hold their last value.
- bvalid stays high and bresp stays stable until bready is sampled high; bvalid deasserts the cycle after.
- bready high while bvalid = 0 is ignored.
- Minimum latency: simultaneous AW/W at edge N -> reg_wr_en in cycle N+1, bvalid from N+2.
- Throughput: at most one write per 3 cycles when bready is tied high.
- awvalid or wvalid asserted while its ready is low: no capture; the master must hold it.
- Address is passed unmodified; no alignment masking.

Optional Feature:
- Macro: AXI_WR_ADDR_RANGE_CHECK_EN.
- Defined, in WRITE:
  - If reg_waddr >= REG_SPACE_BYTES: reg_wr_en is suppressed and bresp = 2'b10 (SLVERR) in RESP.
  - All other timing is unchanged.
- Undefined: no check; bresp is always OKAY; REG_SPACE_BYTES is unused.

Decomposition:
- Package axi_lite_pkg:
  - wr_state_e enum (IDLE, WAIT_W, WAIT_AW, WRITE, RESP).
  - Constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- No sub-module; the FSM and capture registers are a single module.

Test Plan:
- Reset: hold s_axi_areset 2 cycles with awvalid = wvalid = 1 -> all outputs 0 during reset; awready = wready = 1 on the first cycle after release.
- Simultaneous handshake: awaddr = 0x10, wdata = 0xDEADBEEF, wstrb = 0xF at edge N -> both flags high N+1, reg_wr_en pulse N+1 with those values, bvalid from N+2, bresp 00.
- AW first: awaddr = 0x20 at N, wvalid at N+3 -> awaddr_done_reg high N+1..N+4, wready low? no, wready high throughout, awready low N+1..; reg_wr_en at N+4.
- Backpressure: bready low for 5 cycles -> bvalid and bresp held, readies stay 0, no second reg_wr_en; bready high -> IDLE next cycle.
- Reset mid-op: reset asserted in WAIT_W -> no reg_wr_en, flags cleared, a subsequent fresh write completes normally.
- With AXI_WR_ADDR_RANGE_CHECK_EN: awaddr = 0x1000 (REG_SPACE_BYTES = 4096) -> no reg_wr_en, bresp = 2'b10; awaddr = 0xFFC -> write occurs, bresp = 00.
